// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: register index
// width, TUSE/TNEW encodings, mult/div latencies and busy-timer states.
package hazard_ctrl_pkg;

   localparam int REG_W = 5;

   typedef logic [REG_W-1:0] regidx_t;
   typedef logic [1:0]       stage_t;

   // TUSE: cycles until the D instruction consumes an operand.
   localparam stage_t TUSE_0    = 2'd0;
   localparam stage_t TUSE_1    = 2'd1;
   localparam stage_t TUSE_2    = 2'd2;
   localparam stage_t TUSE_NONE = 2'd3;

   // TNEW: cycles until a producer's result can be forwarded.
   localparam stage_t TNEW_0 = 2'd0;
   localparam stage_t TNEW_1 = 2'd1;
   localparam stage_t TNEW_2 = 2'd2;
   localparam stage_t TNEW_3 = 2'd3;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   // Busy-timer states; the state is implied by whether the count is zero.
   localparam logic TIMER_IDLE = 1'b0;
   localparam logic TIMER_BUSY = 1'b1;

   // A consumer stalls on a producer that writes the same non-zero register
   // and cannot forward in time. TUSE_NONE (3) can never be below a TNEW.
   function automatic logic regHazard(input regidx_t src, input stage_t tuse,
                                      input regidx_t dst, input stage_t tnew);
      return (src != '0) && (src == dst) && (tuse < tnew);
   endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div busy timer: a 4-bit down-counter loaded when a mult/div starts
// in E, keeping HI/LO consumers waiting until the result is ready.
module md_busy_timer
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic isDiv,
   output logic busy
);

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

   logic [3:0] cnt;
   logic       state;

   // Timer state follows directly from the count.
   always_comb begin
      state = (cnt != 4'd0) ? TIMER_BUSY : TIMER_IDLE;
   end

   // Load on a start while idle, count down while busy; a start while busy is ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= 4'd0;
      end else begin
         case (state)
            TIMER_IDLE: if (start) cnt <= isDiv ? DIV_LOAD : MULT_LOAD;
            TIMER_BUSY: cnt <= cnt - 4'd1;
            default:    cnt <= 4'd0;
         endcase
      end
   end

   // The count may be stale in the first reset cycle, so busy is masked then.
   always_comb begin
      busy = (state == TIMER_BUSY) && !reset;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the five-stage MIPS pipeline. Decides each
// cycle whether the D-stage instruction may advance, based on register
// hazards against E and M producers and on the mult/div busy timer.
// Optional macro HAZARD_PERF_EN adds stall-cycle performance counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_W-1:0]  rsD,
   input  logic [REG_W-1:0]  rtD,
   input  logic [1:0]        tuseRsD,
   input  logic [1:0]        tuseRtD,
   input  logic [REG_W-1:0]  writeRegE,
   input  logic [1:0]        tnewE,
   input  logic [REG_W-1:0]  writeRegM,
   input  logic [1:0]        tnewM,
   input  logic              mdUseD,
   input  logic              mdStartE,
   input  logic              mdIsDivE,
   output logic              enPC,
   output logic              enIFID,
   output logic              flushIDEX,
   output logic              mdBusy,
   output logic              stallD
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]       stallCycles,
   output logic [31:0]       mdStallCycles
`endif
);

   logic hazRs;
   logic hazRt;
   logic hazMd;

   md_busy_timer #(
      .MULT_CYCLES(MULT_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) uTimer (
      .clk  (clk),
      .reset(reset),
      .start(mdStartE),
      .isDiv(mdIsDivE),
      .busy (mdBusy)
   );

   // Hazard detection against both producers; reset forces the pipeline to run.
   always_comb begin
      hazRs = regHazard(rsD, tuseRsD, writeRegE, tnewE) |
              regHazard(rsD, tuseRsD, writeRegM, tnewM);
      hazRt = regHazard(rtD, tuseRtD, writeRegE, tnewE) |
              regHazard(rtD, tuseRtD, writeRegM, tnewM);
      hazMd = mdUseD & (mdBusy | mdStartE);
      stallD    = !reset && (hazRs || hazRt || hazMd);
      enPC      = !stallD;
      enIFID    = !stallD;
      flushIDEX = stallD;
   end

`ifdef HAZARD_PERF_EN
   // Free-running stall counters, wrapping modulo 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         stallCycles   <= 32'd0;
         mdStallCycles <= 32'd0;
      end else begin
         if (stallD) stallCycles <= stallCycles + 32'd1;
         if (hazMd)  mdStallCycles <= mdStallCycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a table of combinational hazard
// vectors, hand-written mult/div and reset sequences, and randomized
// stimulus compared against a cycle-window model of the busy timer.
module tb_hazard_ctrl;

   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [1:0] tuRs;
      logic [1:0] tuRt;
      logic [4:0] wE;
      logic [1:0] tnE;
      logic [4:0] wM;
      logic [1:0] tnM;
      logic       expStall;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   logic [4:0] rsD, rtD, writeRegE, writeRegM;
   logic [1:0] tuseRsD, tuseRtD, tnewE, tnewM;
   logic mdUseD, mdStartE, mdIsDivE;
   logic enPC, enIFID, flushIDEX, mdBusy, stallD;
`ifdef HAZARD_PERF_EN
   logic [31:0] stallCycles, mdStallCycles;
`endif

   int checks = 0;
   int passes = 0;

   hazard_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .rsD      (rsD),
      .rtD      (rtD),
      .tuseRsD  (tuseRsD),
      .tuseRtD  (tuseRtD),
      .writeRegE(writeRegE),
      .tnewE    (tnewE),
      .writeRegM(writeRegM),
      .tnewM    (tnewM),
      .mdUseD   (mdUseD),
      .mdStartE (mdStartE),
      .mdIsDivE (mdIsDivE),
      .enPC     (enPC),
      .enIFID   (enIFID),
      .flushIDEX(flushIDEX),
      .mdBusy   (mdBusy),
      .stallD   (stallD)
`ifdef HAZARD_PERF_EN
      ,
      .stallCycles  (stallCycles),
      .mdStallCycles(mdStallCycles)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic checkStall(input string name, input logic exp);
      checkOutput({name, ".stallD"}, {31'd0, stallD}, {31'd0, exp});
      checkOutput({name, ".enPC"}, {31'd0, enPC}, {31'd0, !exp});
      checkOutput({name, ".enIFID"}, {31'd0, enIFID}, {31'd0, !exp});
      checkOutput({name, ".flushIDEX"}, {31'd0, flushIDEX}, {31'd0, exp});
   endtask

   task automatic clearInputs();
      rsD = 0; rtD = 0; tuseRsD = 3; tuseRtD = 3;
      writeRegE = 0; tnewE = 0; writeRegM = 0; tnewM = 0;
      mdUseD = 0; mdStartE = 0; mdIsDivE = 0;
   endtask

   task automatic applyStimulus(input vec_t v);
      rsD = v.rs; rtD = v.rt; tuseRsD = v.tuRs; tuseRtD = v.tuRt;
      writeRegE = v.wE; tnewE = v.tnE; writeRegM = v.wM; tnewM = v.tnM;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic refHaz(input logic [4:0] src, input logic [1:0] tu,
                                   input logic [4:0] dst, input logic [1:0] tn);
      return (src != 0) && (src == dst) && (int'(tu) < int'(tn));
   endfunction

   vec_t vecs[9];

   initial begin
      int cyc;
      int busyFrom;
      int busyTo;
      logic expBusy;
      logic expStall;

      // ---------------- reset behaviour ----------------
      clearInputs();
      reset = 1;
      rsD = 1; tuseRsD = 0; writeRegE = 1; tnewE = 2; mdUseD = 1; mdStartE = 1;
      #1;
      checkStall("resetPre", 1'b0);
      checkOutput("resetPre.mdBusy", {31'd0, mdBusy}, 32'd0);
      tick();
      checkStall("resetHeld", 1'b0);
      checkOutput("resetHeld.mdBusy", {31'd0, mdBusy}, 32'd0);
      clearInputs();
      reset = 0;
      tick();
      checkOutput("postReset.mdBusy", {31'd0, mdBusy}, 32'd0);

      // ---------------- table-driven register hazards ----------------
      vecs[0] = '{rs:1, rt:0, tuRs:0, tuRt:3, wE:1, tnE:2, wM:0, tnM:0, expStall:1};
      vecs[1] = '{rs:1, rt:0, tuRs:0, tuRt:3, wE:0, tnE:0, wM:1, tnM:1, expStall:1};
      vecs[2] = '{rs:1, rt:0, tuRs:0, tuRt:3, wE:0, tnE:0, wM:1, tnM:0, expStall:0};
      vecs[3] = '{rs:0, rt:0, tuRs:0, tuRt:3, wE:0, tnE:2, wM:0, tnM:0, expStall:0};
      vecs[4] = '{rs:0, rt:5, tuRs:3, tuRt:1, wE:5, tnE:1, wM:0, tnM:0, expStall:0};
      vecs[5] = '{rs:0, rt:5, tuRs:3, tuRt:0, wE:0, tnE:0, wM:5, tnM:1, expStall:1};
      vecs[6] = '{rs:7, rt:0, tuRs:3, tuRt:3, wE:7, tnE:2, wM:7, tnM:2, expStall:0};
      vecs[7] = '{rs:2, rt:0, tuRs:1, tuRt:3, wE:2, tnE:1, wM:2, tnM:2, expStall:1};
      vecs[8] = '{rs:3, rt:4, tuRs:0, tuRt:0, wE:6, tnE:3, wM:6, tnM:3, expStall:0};
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkStall($sformatf("vec%0d", i), vecs[i].expStall);
         tick();
      end
      clearInputs();

      // ---------------- lw-use sequence ----------------
      rsD = 1; tuseRsD = 0; writeRegE = 1; tnewE = 2;
      #1;
      checkStall("lwUse.c1", 1'b1);
      tick();
      writeRegE = 0; tnewE = 0; writeRegM = 1; tnewM = 1;
      #1;
      checkStall("lwUse.c2", 1'b1);
      tick();
      tnewM = 0;
      #1;
      checkStall("lwUse.c3", 1'b0);
      tick();
      clearInputs();

      // ---------------- mult with HI/LO consumer in D ----------------
      mdUseD = 1; mdStartE = 1; mdIsDivE = 0;
      #1;
      checkStall("mult.c0", 1'b1);
      checkOutput("mult.c0.mdBusy", {31'd0, mdBusy}, 32'd0);
      tick();
      mdStartE = 0;
      for (int c = 1; c <= 6; c++) begin
         #1;
         checkOutput($sformatf("mult.c%0d.mdBusy", c), {31'd0, mdBusy}, {31'd0, c <= 5});
         checkOutput($sformatf("mult.c%0d.stallD", c), {31'd0, stallD}, {31'd0, c <= 5});
         tick();
      end
      clearInputs();

      // ---------------- div: full duration ----------------
      mdStartE = 1; mdIsDivE = 1;
      tick();
      clearInputs();
      for (int c = 1; c <= 11; c++) begin
         #1;
         checkOutput($sformatf("div.c%0d.mdBusy", c), {31'd0, mdBusy}, {31'd0, c <= 10});
         tick();
      end

      // ---------------- div aborted by reset at cycle 4 ----------------
      mdStartE = 1; mdIsDivE = 1; mdUseD = 1;
      tick();
      mdStartE = 0;
      for (int c = 1; c <= 3; c++) begin
         #1;
         checkOutput($sformatf("divRst.c%0d.mdBusy", c), {31'd0, mdBusy}, 32'd1);
         tick();
      end
      reset = 1;
      #1;
      checkOutput("divRst.c4.mdBusy", {31'd0, mdBusy}, 32'd0);
      checkStall("divRst.c4", 1'b0);
      tick();
      reset = 0;
      #1;
      checkOutput("divRst.c5.mdBusy", {31'd0, mdBusy}, 32'd0);
      checkOutput("divRst.c5.stallD", {31'd0, stallD}, 32'd0);
      tick();
      clearInputs();

`ifdef HAZARD_PERF_EN
      // ---------------- performance counters ----------------
      reset = 1;
      tick();
      reset = 0;
      for (int k = 0; k < 3; k++) begin
         rsD = 1; tuseRsD = 0; writeRegE = 1; tnewE = 2;
         tick();
         clearInputs();
         tick();
      end
      mdUseD = 1; mdStartE = 1; mdIsDivE = 0;
      tick();
      mdStartE = 0;
      repeat (5) tick();
      clearInputs();
      #1;
      checkOutput("perf.stallCycles", stallCycles, 32'd9);
      checkOutput("perf.mdStallCycles", mdStallCycles, 32'd6);
      tick();
`endif

      // ---------------- randomized against window model ----------------
      reset = 1;
      tick();
      reset = 0;
      cyc = 0;
      busyFrom = 1;
      busyTo = 0;
      for (int it = 0; it < 400; it++) begin
         rsD = 5'($urandom_range(0, 3));
         rtD = 5'($urandom_range(0, 3));
         tuseRsD = 2'($urandom_range(0, 3));
         tuseRtD = 2'($urandom_range(0, 3));
         writeRegE = 5'($urandom_range(0, 3));
         writeRegM = 5'($urandom_range(0, 3));
         tnewE = 2'($urandom_range(0, 3));
         tnewM = 2'($urandom_range(0, 3));
         mdUseD = 1'($urandom_range(0, 1));
         mdIsDivE = 1'($urandom_range(0, 1));
         reset = ($urandom_range(0, 39) == 0);
         expBusy = !reset && (cyc >= busyFrom) && (cyc <= busyTo);
         mdStartE = !expBusy && ($urandom_range(0, 5) == 0);
         expStall = !reset && (
            refHaz(rsD, tuseRsD, writeRegE, tnewE) || refHaz(rsD, tuseRsD, writeRegM, tnewM) ||
            refHaz(rtD, tuseRtD, writeRegE, tnewE) || refHaz(rtD, tuseRtD, writeRegM, tnewM) ||
            (mdUseD && (expBusy || mdStartE)));
         #1;
         checkOutput($sformatf("rand%0d.mdBusy", it), {31'd0, mdBusy}, {31'd0, expBusy});
         checkOutput($sformatf("rand%0d.stallD", it), {31'd0, stallD}, {31'd0, expStall});
         checkOutput($sformatf("rand%0d.enPC", it), {31'd0, enPC}, {31'd0, !expStall});
         checkOutput($sformatf("rand%0d.flushIDEX", it), {31'd0, flushIDEX}, {31'd0, expStall});
         if (reset) begin
            busyTo = cyc;
         end else if (mdStartE) begin
            busyFrom = cyc + 1;
            busyTo = cyc + (mdIsDivE ? 10 : 5);
         end
         tick();
         cyc++;
      end
      reset = 0;
      clearInputs();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline stall/flush controller for the five-stage MIPS core. Each cycle it decides whether the instruction in D may advance. It drives the enable of the IF/ID register and the PC, and the bubble-insert (flush) of the ID/EX register. It also owns the multiply/divide busy timer, so that HI/LO-using instructions wait for an in-flight mult/div to finish.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration after mult/multu start
- DIV_CYCLES, 10, busy duration after div/divu start

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- rsD  in  5  D-stage rs field
- rtD  in  5  D-stage rt field
- tuseRsD  in  2  cycles until D instr needs rs (3 = not used)
- tuseRtD  in  2  cycles until D instr needs rt (3 = not used)
- writeRegE  in  5  E-stage destination register
- tnewE  in  2  cycles until E result is forwardable
- writeRegM  in  5  M-stage destination register
- tnewM  in  2  cycles until M result is forwardable
- mdUseD  in  1  D instr is mult/div/mfhi/mflo/mthi/mtlo
- mdStartE  in  1  E instr starts mult/div this cycle
- mdIsDivE  in  1  started op is div/divu (valid with mdStartE)
- enPC  out  1  PC write enable
- enIFID  out  1  IF/ID register enable
- flushIDEX  out  1  clear ID/EX (insert bubble) at next edge
- mdBusy  out  1  mult/div unit busy
- stallD  out  1  D stage stalled this cycle

## Operation
- Register hazard on rs: rsD != 0 and tuseRsD < tnew of a matching producer.
  - A producer is E (rsD == writeRegE, tnewE) or M (rsD == writeRegM, tnewM).
  - Both producers are checked independently.
- Register hazard on rt: same rule with rtD and tuseRtD.
- Register $0 never causes a stall.
- MD hazard: mdUseD and (mdBusy or mdStartE).
- stallD is the OR of the three hazards and is combinational.
- Output derivation: enPC = enIFID = ~stallD; flushIDEX = stallD.
- Busy timer: 4-bit down-counter `cnt`, with mdBusy = (cnt != 0).
  - On mdStartE with cnt == 0: load DIV_CYCLES if mdIsDivE, otherwise MULT_CYCLES.
  - Else if cnt != 0: decrement.
  - mdStartE while cnt != 0 is ignored; this is illegal upstream and the MD stall prevents it.
- Timer states: IDLE (cnt = 0) and BUSY (cnt > 0).
  - IDLE to BUSY on mdStartE.
  - BUSY to IDLE when cnt reaches 0.

## Timing
- Hazard outputs are valid in the same cycle as their inputs. There is no registered latency on stall.
- mdStartE at edge t: mdBusy is high for cycles t+1 through t+N, where N is the loaded value, and low at t+N+1.
- A D-stage HI/LO instruction aligned with mdStartE stalls N+1 cycles.
- Reset: the clocked counter is cleared at the edge where reset is sampled. While reset is high:
  - Stall logic is forced off: enPC = enIFID = 1, flushIDEX = 0, stallD = 0.
  - mdBusy = 0.
- Reset mid-operation abandons the count. mdBusy is 0 in the cycle after reset deasserts.
- When E and M both match, the stall is taken if either condition holds.

## Configuration
- HAZARD_PERF_EN defined: adds outputs stallCycles [31:0] and mdStallCycles [31:0].
  - stallCycles increments every cycle stallD = 1.
  - mdStallCycles increments every cycle the MD hazard alone or jointly is true.
  - Both are cleared by reset and wrap modulo 2^32.
- HAZARD_PERF_EN undefined: neither port nor either counter exists.

## Structure
- Shared package holds:
  - TUSE/TNEW 2-bit encodings, including TUSE_NONE = 3.
  - MULT_CYCLES and DIV_CYCLES defaults.
  - Register index width 5.
- One sub-module, md_busy_timer.
  - Ports: clk, reset, start, isDiv, busy.
  - Contains the counter and load logic.
- Hazard comparison stays in hazard_ctrl.

## Test plan
- rsD=1, tuseRsD=0, writeRegE=1, tnewE=2 (lw in E):
  - Cycle 1: stallD=1, enIFID=0, flushIDEX=1.
  - Next cycle, with writeRegM=1, tnewM=1, tuseRsD=0: stall persists.
  - With tnewM=0: stallD=0.
- rsD=0, writeRegE=0, tnewE=2, tuseRsD=0: stallD=0.
- rtD=5, tuseRtD=1, writeRegE=5, tnewE=1: stallD=0, since tuse is not less than tnew.
- mdStartE=1, mdIsDivE=0 at edge 0, with mdUseD held 1:
  - mdBusy high cycles 1–5.
  - stallD high cycles 0–5, low at cycle 6.
- Div start: mdBusy high for exactly 10 cycles.
  - Reset asserted at cycle 4 gives mdBusy=0 from the following cycle.
  - stallD=0 during reset.
- HAZARD_PERF_EN defined: 3 lw-use stalls followed by a mult with mfhi in D give:
  - stallCycles = 9.
  - mdStallCycles = 6.
